// File: rtl/systolic_feed_scheduler_if.sv
// Handshake and bank/array bus between the instruction sequencer, the feed scheduler and the A/B/O banks.
// The scheduler connects through the slave modport; the sequencer side uses master.
interface systolic_feed_scheduler_if #(
  parameter int AW    = 16,
  parameter int LANES = 4
);
  logic                start;
  logic [AW-1:0]       k_len;
  logic [AW-1:0]       a_base;
  logic [AW-1:0]       b_base;
  logic [AW-1:0]       o_base;
  logic                busy;
  logic                done;
  logic                err;
  logic                pe_clr;
  logic                pe_en;
  logic [LANES*AW-1:0] a_addr;
  logic [LANES-1:0]    a_vld;
  logic [LANES*AW-1:0] b_addr;
  logic [LANES-1:0]    b_vld;
  logic                o_we;
  logic [AW-1:0]       o_ptr;

  modport master (
    output start, k_len, a_base, b_base, o_base,
    input  busy, done, err, pe_clr, pe_en, a_addr, a_vld, b_addr, b_vld, o_we, o_ptr
  );

  modport slave (
    input  start, k_len, a_base, b_base, o_base,
    output busy, done, err, pe_clr, pe_en, a_addr, a_vld, b_addr, b_vld, o_we, o_ptr
  );
endinterface

// File: rtl/systolic_feed_scheduler.sv
// Sequences one LANESxLANES tile multiply: clear, skewed A/B feed, drain, output writeback, done.
// Optional SCHED_HOLD_EN adds a hold input that stalls FEED and DRAIN.
module systolic_feed_scheduler #(
  parameter int AW        = 16,
  parameter int LANES     = 4,
  parameter int DRAIN     = 8,
  parameter int IDLE_ADDR = 255
) (
  input  logic clk,
  input  logic rst,
`ifdef SCHED_HOLD_EN
  input  logic hold,
`endif
  systolic_feed_scheduler_if.slave bus
);

  // t must reach K+LANES-2 without wrapping for any AW-bit K.
  localparam int TW = AW + 2;
  localparam logic [AW-1:0] IDLE_A     = AW'(IDLE_ADDR);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_FEED, ST_DRAIN, ST_WRITE, ST_DONE
  } state_t;

  state_t              state;
  logic [TW-1:0]       t;
  logic [AW-1:0]       kLat, aBase, bBase, oBase;
  logic                holdIn;
  logic [TW-1:0]       tFeed, feedLast;
  logic [LANES*AW-1:0] feedA, feedB;
  logic [LANES-1:0]    feedV;

`ifdef SCHED_HOLD_EN
  assign holdIn = hold;
`else
  assign holdIn = 1'b0;
`endif

  // Lane pattern for the feed step about to be registered.
  assign tFeed    = (state == ST_FEED) ? t + 1'b1 : '0;
  assign feedLast = TW'(kLat) + TW'(LANES - 2);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    feedA = {LANES{IDLE_A}};
    feedB = {LANES{IDLE_A}};
    feedV = '0;
    for (int i = 0; i < LANES; i++) begin
      if (tFeed >= TW'(i) && tFeed < TW'(kLat) + TW'(i)) begin
        feedV[i]            = 1'b1;
        feedA[i*AW +: AW]   = aBase + AW'(tFeed - TW'(i)) + AW'(i) * kLat;
        feedB[i*AW +: AW]   = bBase + AW'(tFeed - TW'(i)) * AW'(LANES) + AW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      t          <= '0;
      kLat       <= '0;
      aBase      <= '0;
      bBase      <= '0;
      oBase      <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.pe_clr <= 1'b0;
      bus.pe_en  <= 1'b0;
      bus.o_we   <= 1'b0;
      bus.o_ptr  <= '0;
      bus.a_addr <= {LANES{IDLE_A}};
      bus.b_addr <= {LANES{IDLE_A}};
      bus.a_vld  <= '0;
      bus.b_vld  <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.pe_clr <= 1'b0;
      bus.o_we   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            kLat     <= bus.k_len;
            aBase    <= bus.a_base;
            bBase    <= bus.b_base;
            oBase    <= bus.o_base;
            bus.busy <= 1'b1;
            if (bus.k_len == '0) begin
              state    <= ST_DONE;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else begin
              state      <= ST_CLEAR;
              bus.pe_clr <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          state      <= ST_FEED;
          t          <= '0;
          bus.pe_en  <= 1'b1;
          bus.a_addr <= feedA;
          bus.b_addr <= feedB;
          bus.a_vld  <= feedV;
          bus.b_vld  <= feedV;
        end
        ST_FEED: begin
          if (holdIn) begin
            bus.pe_en <= 1'b0;
          end else begin
            bus.pe_en <= 1'b1;
            if (t == feedLast) begin
              state      <= ST_DRAIN;
              t          <= '0;
              bus.a_addr <= {LANES{IDLE_A}};
              bus.b_addr <= {LANES{IDLE_A}};
              bus.a_vld  <= '0;
              bus.b_vld  <= '0;
            end else begin
              t          <= t + 1'b1;
              bus.a_addr <= feedA;
              bus.b_addr <= feedB;
              bus.a_vld  <= feedV;
              bus.b_vld  <= feedV;
            end
          end
        end
        ST_DRAIN: begin
          if (holdIn) begin
            bus.pe_en <= 1'b0;
          end else if (t == DRAIN_LAST) begin
            state     <= ST_WRITE;
            t         <= '0;
            bus.pe_en <= 1'b0;
            bus.o_we  <= 1'b1;
            bus.o_ptr <= oBase;
          end else begin
            bus.pe_en <= 1'b1;
            t         <= t + 1'b1;
          end
        end
        ST_WRITE: begin
          state    <= ST_DONE;
          bus.done <= 1'b1;
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Self-checking bench for systolic_feed_scheduler: directed and random tiles against a cycle-timeline model.
module tb_systolic_feed_scheduler;
  localparam int AW        = 16;
  localparam int LANES     = 4;
  localparam int DRAIN     = 8;
  localparam int IDLE_ADDR = 255;

  logic clk = 1'b0;
  logic rst;
`ifdef SCHED_HOLD_EN
  logic hold;
`endif

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] expOptr;

  systolic_feed_scheduler_if #(.AW(AW), .LANES(LANES)) bus ();

  systolic_feed_scheduler #(
    .AW(AW), .LANES(LANES), .DRAIN(DRAIN), .IDLE_ADDR(IDLE_ADDR)
  ) dut (
    .clk (clk),
    .rst (rst),
`ifdef SCHED_HOLD_EN
    .hold(hold),
`endif
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for cycle e after the start-sampling edge (e=0: idle). Frozen marks a held cycle.
  task automatic check_cycle(input int e, input bit frozen, input int k,
                             input logic [AW-1:0] a, input logic [AW-1:0] b,
                             input logic [AW-1:0] o, input string tag);
    int total;
    int t;
    bit feeding;
    logic [LANES*AW-1:0] ea, eb;
    logic [LANES-1:0]    ev;
    total   = (k == 0) ? 1 : k + 6 + DRAIN;
    t       = e - 2;
    feeding = (k != 0) && e >= 2 && e <= k + LANES;
    ev      = '0;
    for (int i = 0; i < LANES; i++) begin
      ea[i*AW +: AW] = AW'(IDLE_ADDR);
      eb[i*AW +: AW] = AW'(IDLE_ADDR);
      if (feeding && t >= i && t < k + i) begin
        ev[i]          = 1'b1;
        ea[i*AW +: AW] = AW'(a + (t - i) + i * k);
        eb[i*AW +: AW] = AW'(b + (t - i) * LANES + i);
      end
    end
    if (k != 0 && e == k + 5 + DRAIN) expOptr = o;
    check($sformatf("%s busy e=%0d", tag, e),   bus.busy,   e >= 1 && e <= total);
    check($sformatf("%s done e=%0d", tag, e),   bus.done,   e == total);
    check($sformatf("%s err e=%0d", tag, e),    bus.err,    k == 0 && e == 1);
    check($sformatf("%s pe_clr e=%0d", tag, e), bus.pe_clr, k != 0 && e == 1);
    check($sformatf("%s pe_en e=%0d", tag, e),  bus.pe_en,
          k != 0 && e >= 2 && e <= k + 4 + DRAIN && !frozen);
    check($sformatf("%s o_we e=%0d", tag, e),   bus.o_we,   k != 0 && e == k + 5 + DRAIN);
    check($sformatf("%s o_ptr e=%0d", tag, e),  bus.o_ptr,  expOptr);
    check($sformatf("%s a_addr e=%0d", tag, e), bus.a_addr, ea);
    check($sformatf("%s b_addr e=%0d", tag, e), bus.b_addr, eb);
    check($sformatf("%s a_vld e=%0d", tag, e),  bus.a_vld,  ev);
    check($sformatf("%s b_vld e=%0d", tag, e),  bus.b_vld,  ev);
  endtask

  // Runs one tile from a start pulse to the idle cycle after done, scrambling inputs while busy.
  task automatic run_tile(input int k, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] o, input int spurious, input bit startInDone,
                          input int holdFrom, input int holdLen, input string tag);
    int  total;
    int  e;
    bit  frozen;
    bit  holdNow;
    total      = (k == 0) ? 1 : k + 6 + DRAIN;
    e          = 0;
    holdNow    = 1'b0;
    bus.k_len  = AW'(k);
    bus.a_base = a;
    bus.b_base = b;
    bus.o_base = o;
    bus.start  = 1'b1;
    for (int n = 1; n <= total + 1 + holdLen; n++) begin
      @(posedge clk);
      #1;
      frozen = holdNow && k != 0 && e >= 2 && e <= k + 4 + DRAIN;
      if (!frozen) e++;
      holdNow = (n >= holdFrom) && (n < holdFrom + holdLen);
`ifdef SCHED_HOLD_EN
      hold = holdNow;
`endif
      bus.start  = (n == spurious) || (startInDone && e == total);
      bus.k_len  = AW'($urandom);
      bus.a_base = AW'($urandom);
      bus.b_base = AW'($urandom);
      bus.o_base = AW'($urandom);
      check_cycle(e, frozen, k, a, b, o, tag);
    end
    bus.start = 1'b0;
`ifdef SCHED_HOLD_EN
    hold = 1'b0;
`endif
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.k_len  = '0;
    bus.a_base = '0;
    bus.b_base = '0;
    bus.o_base = '0;
    expOptr    = '0;
`ifdef SCHED_HOLD_EN
    hold = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_cycle(0, 1'b0, 0, '0, '0, '0, "reset");
    rst = 1'b0;

    run_tile(4, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 0, 0, "k4_base0");
    run_tile(1, 16'h0010, 16'h0020, 16'h0040, 0, 1'b0, 0, 0, "k1");
    run_tile(0, 16'h1234, 16'h5678, 16'h0099, 0, 1'b0, 0, 0, "k0");
    run_tile(4, 16'h0100, 16'h0200, 16'h0077, 5, 1'b1, 0, 0, "start_busy");
    run_tile(3, 16'hFFFE, 16'hFFF0, 16'h0abc, 0, 1'b0, 0, 0, "after_done_wrap");

    // Abort mid-FEED: rst high during cycle 4, outputs back at reset values in cycle 5.
    bus.k_len  = 16'd4;
    bus.a_base = 16'h0300;
    bus.b_base = 16'h0400;
    bus.o_base = 16'h0055;
    bus.start  = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_cycle(n, 1'b0, 4, 16'h0300, 16'h0400, 16'h0055, "pre_abort");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    expOptr = '0;
    for (int n = 0; n < DRAIN + 8; n++) begin
      check_cycle(0, 1'b0, 0, '0, '0, '0, "aborted");
      @(posedge clk);
      #1;
    end
    run_tile(4, 16'h0500, 16'h0600, 16'h0066, 0, 1'b0, 0, 0, "post_abort");

`ifdef SCHED_HOLD_EN
    run_tile(4, 16'h0000, 16'h0000, 16'h0011, 0, 1'b0, 4, 3, "hold_feed");
    run_tile(2, 16'h0020, 16'h0030, 16'h0022, 0, 1'b0, 9, 2, "hold_drain");
`endif

    for (int r = 0; r < 8; r++) begin
      run_tile(int'($urandom_range(0, 9)), AW'($urandom), AW'($urandom), AW'($urandom),
               int'($urandom_range(2, 10)), 1'($urandom), 0, 0, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
